// File: rtl/alu_share_ctrl.sv
// Round-robin controller sharing one aluN between two requesters: one operation
// in flight at a time, result held on a per-requester response handshake.
module alu_share_ctrl #(
  parameter int N = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [1:0]     req_valid_i,
  output logic [1:0]     req_ready_o,
  input  logic [2*N-1:0] req_a_i,
  input  logic [2*N-1:0] req_b_i,
  input  logic [1:0]     req_c_i,
  input  logic [7:0]     req_ope_i,
  output logic [N-1:0]   alu_a_o,
  output logic [N-1:0]   alu_b_o,
  output logic           alu_c_o,
  output logic [3:0]     alu_ope_o,
  input  logic [N-1:0]   alu_sal_i,
  input  logic           alu_c_i,
  output logic [1:0]     rsp_valid_o,
  input  logic [1:0]     rsp_ready_i,
  output logic [N-1:0]   rsp_sal_o,
  output logic           rsp_c_o,
  output logic           busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           prio_q, prio_d;
  logic           own_q, own_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           c_q, c_d;
  logic [3:0]     ope_q, ope_d;
  logic [N-1:0]   sal_q, sal_d;
  logic           co_q, co_d;

  logic           gnt_any;
  logic           gnt_idx;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic           sel_c;
  logic [3:0]     sel_ope;

  // Priority only matters on contention; a lone requester wins outright.
  always_comb begin
    gnt_any = |req_valid_i;
    gnt_idx = (&req_valid_i) ? prio_q : req_valid_i[1];
    sel_a   = gnt_idx ? req_a_i[2*N-1:N] : req_a_i[N-1:0];
    sel_b   = gnt_idx ? req_b_i[2*N-1:N] : req_b_i[N-1:0];
    sel_c   = req_c_i[gnt_idx];
    sel_ope = gnt_idx ? req_ope_i[7:4] : req_ope_i[3:0];
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    own_d       = own_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    ope_d       = ope_q;
    sal_d       = sal_q;
    co_d        = co_q;
    req_ready_o = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          req_ready_o = {gnt_idx, ~gnt_idx};
          a_d         = sel_a;
          b_d         = sel_b;
          c_d         = sel_c;
          ope_d       = sel_ope;
          own_d       = gnt_idx;
          prio_d      = ~gnt_idx;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        sal_d   = alu_sal_i;
        co_d    = alu_c_i;
        state_d = RESP;
      end
      RESP: begin
        // Returning through IDLE keeps arbitration in one place.
        if (rsp_ready_i[own_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      own_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      ope_q   <= 4'h0;
      sal_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      own_q   <= own_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      ope_q   <= ope_d;
      sal_q   <= sal_d;
      co_q    <= co_d;
    end
  end

  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_c_o     = c_q;
  assign alu_ope_o   = ope_q;
  assign rsp_sal_o   = sal_q;
  assign rsp_c_o     = co_q;
  assign rsp_valid_o = (state_q == RESP) ? {own_q, ~own_q} : 2'b00;
  assign busy_o      = (state_q != IDLE);

endmodule
